// File: rtl/nes_flash_arb_pkg.sv
// Shared constants and types for the NOR flash arbiter.
// Imported by the request slot and the top level.
package nes_flash_arb_pkg;

  localparam int FL_ADDR_W = 23;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_PPU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } st_e;

  // On a tie the port that was not served last wins.
  function automatic logic rr_pick(
    input logic [1:0] i_elig,
    input logic       i_last
  );
    logic w_g;
    if (i_elig == 2'b11) w_g = ~i_last;
    else                 w_g = i_elig[1];
    return w_g;
  endfunction

endpackage

// File: rtl/nes_flash_req_slot.sv
// One pending-request slot: pending bit, captured address
// and sticky drop flag.
module nes_flash_req_slot
  import nes_flash_arb_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_req,
  input  logic [FL_ADDR_W-1:0] i_addr,
  input  logic                 i_clr,
  output logic                 o_pend,
  output logic [FL_ADDR_W-1:0] o_addr,
  output logic                 o_drop
);

  logic                 r_pend;
  logic [FL_ADDR_W-1:0] r_addr;
  logic                 r_drop;
  logic                 w_take;

  // A pulse on the clearing edge starts a fresh request.
  assign w_take = i_req & (~r_pend | i_clr);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pend <= 1'b0;
      r_addr <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_take) begin
        r_pend <= 1'b1;
        r_addr <= i_addr;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
      if (i_req & ~w_take) r_drop <= 1'b1;
    end
  end

  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_drop = r_drop;

endmodule

// File: rtl/nes_flash_arb.sv
// Round-robin read sequencer for the shared NOR flash
// between CPU PRG and PPU CHR fetches.
module nes_flash_arb
  import nes_flash_arb_pkg::*;
#(
  parameter int FL_WAIT = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_cpu_req,
  input  logic [FL_ADDR_W-1:0] i_cpu_addr,
  output logic                 o_cpu_ack,
  output logic [7:0]           o_cpu_rdata,
  input  logic                 i_ppu_req,
  input  logic [FL_ADDR_W-1:0] i_ppu_addr,
  output logic                 o_ppu_ack,
  output logic [7:0]           o_ppu_rdata,
  output logic [FL_ADDR_W-1:0] o_fl_addr,
  output logic                 o_fl_ce_n,
  output logic                 o_fl_oe_n,
  input  logic [7:0]           i_fl_rdata,
  output logic                 o_busy,
  output logic [1:0]           o_drop
);

  localparam logic [3:0] LP_CNT0 = 4'(FL_WAIT - 1);

  st_e                  r_st;
  st_e                  w_nxt;
  logic                 r_gnt;
  logic                 r_last;
  logic [3:0]           r_cnt;
  logic [FL_ADDR_W-1:0] r_fl_addr;
  logic                 r_ce_n;
  logic                 r_oe_n;
  logic                 r_busy;
  logic                 r_cpu_ack;
  logic                 r_ppu_ack;
  logic [7:0]           r_cpu_rdata;
  logic [7:0]           r_ppu_rdata;

  logic [1:0]           w_pend;
  logic [1:0]           w_clr;
  logic [FL_ADDR_W-1:0] w_cpu_saddr;
  logic [FL_ADDR_W-1:0] w_ppu_saddr;
  logic [1:0]           w_elig;
  logic                 w_pick;
  logic [FL_ADDR_W-1:0] w_pick_addr;
  logic                 w_ce_n_d;
  logic                 w_oe_n_d;
  logic                 w_busy_d;
  logic                 w_cpu_ack_d;
  logic                 w_ppu_ack_d;
  logic                 w_load;
  logic                 w_latch;

  assign w_clr[0] = (r_st == ST_DONE) & (r_gnt == PORT_CPU);
  assign w_clr[1] = (r_st == ST_DONE) & (r_gnt == PORT_PPU);

  nes_flash_req_slot u_slot_cpu (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_req  (i_cpu_req),
    .i_addr (i_cpu_addr),
    .i_clr  (w_clr[0]),
    .o_pend (w_pend[0]),
    .o_addr (w_cpu_saddr),
    .o_drop (o_drop[0])
  );

  nes_flash_req_slot u_slot_ppu (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_req  (i_ppu_req),
    .i_addr (i_ppu_addr),
    .i_clr  (w_clr[1]),
    .o_pend (w_pend[1]),
    .o_addr (w_ppu_saddr),
    .o_drop (o_drop[1])
  );

  // In DONE the served port only counts if it re-pulsed now.
  always_comb begin
    w_elig      = 2'b00;
    w_pick_addr = w_cpu_saddr;
    if (r_st == ST_IDLE) begin
      w_elig = w_pend;
    end else if (r_st == ST_DONE) begin
      w_elig[0] = (r_gnt == PORT_CPU) ? i_cpu_req : w_pend[0];
      w_elig[1] = (r_gnt == PORT_PPU) ? i_ppu_req : w_pend[1];
    end
    w_pick = rr_pick(w_elig, r_last);
    if (w_pick == PORT_PPU) begin
      if (r_st == ST_DONE && r_gnt == PORT_PPU) w_pick_addr = i_ppu_addr;
      else                                      w_pick_addr = w_ppu_saddr;
    end else begin
      if (r_st == ST_DONE && r_gnt == PORT_CPU) w_pick_addr = i_cpu_addr;
      else                                      w_pick_addr = w_cpu_saddr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_st <= ST_IDLE;
    else         r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      ST_IDLE:  if (|w_elig) w_nxt = ST_SETUP;
      ST_SETUP: w_nxt = ST_WAIT;
      ST_WAIT:  if (r_cnt == 4'd0) w_nxt = ST_DONE;
      ST_DONE:  w_nxt = (|w_elig) ? ST_SETUP : ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state.
  always_comb begin
    w_ce_n_d    = ~((w_nxt == ST_SETUP) | (w_nxt == ST_WAIT));
    w_oe_n_d    = (w_nxt != ST_WAIT);
    w_busy_d    = (w_nxt != ST_IDLE);
    w_cpu_ack_d = (w_nxt == ST_DONE) & (r_gnt == PORT_CPU);
    w_ppu_ack_d = (w_nxt == ST_DONE) & (r_gnt == PORT_PPU);
    w_load      = (w_nxt == ST_SETUP);
    w_latch     = (r_st == ST_WAIT) & (r_cnt == 4'd0);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_gnt       <= PORT_CPU;
      r_last      <= PORT_CPU;
      r_cnt       <= 4'd0;
      r_fl_addr   <= '0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ppu_ack   <= 1'b0;
      r_cpu_rdata <= 8'h00;
      r_ppu_rdata <= 8'h00;
    end else begin
      r_ce_n    <= w_ce_n_d;
      r_oe_n    <= w_oe_n_d;
      r_busy    <= w_busy_d;
      r_cpu_ack <= w_cpu_ack_d;
      r_ppu_ack <= w_ppu_ack_d;
      if (w_load) begin
        r_gnt     <= w_pick;
        r_last    <= w_pick;
        r_fl_addr <= w_pick_addr;
      end
      if (r_st == ST_SETUP)
        r_cnt <= LP_CNT0;
      else if (r_st == ST_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_latch && r_gnt == PORT_CPU) r_cpu_rdata <= i_fl_rdata;
      if (w_latch && r_gnt == PORT_PPU) r_ppu_rdata <= i_fl_rdata;
    end
  end

  assign o_fl_addr   = r_fl_addr;
  assign o_fl_ce_n   = r_ce_n;
  assign o_fl_oe_n   = r_oe_n;
  assign o_busy      = r_busy;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_ppu_ack   = r_ppu_ack;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_ppu_rdata = r_ppu_rdata;

endmodule

// File: tb/tb_nes_flash_arb.sv
// Directed and randomized bench for nes_flash_arb with a
// transaction-level scoreboard and a simple flash model.
module tb_nes_flash_arb;

  localparam int FW = 6;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_req = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ppu_req = 1'b0;
  logic [22:0] ppu_addr = '0;
  logic        ppu_ack;
  logic [7:0]  ppu_rdata;
  logic [22:0] fl_addr;
  logic        fl_ce_n;
  logic        fl_oe_n;
  logic [7:0]  fl_rdata;
  logic        busy;
  logic [1:0]  drop;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] fdat(input logic [22:0] a);
    return 8'hA5 ^ a[7:0] ^ {1'b0, a[22:16]};
  endfunction

  assign fl_rdata = fl_oe_n ? 8'h00 : fdat(fl_addr);

  nes_flash_arb #(.FL_WAIT(FW)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cpu_req   (cpu_req),
    .i_cpu_addr  (cpu_addr),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_rdata (cpu_rdata),
    .i_ppu_req   (ppu_req),
    .i_ppu_addr  (ppu_addr),
    .o_ppu_ack   (ppu_ack),
    .o_ppu_rdata (ppu_rdata),
    .o_fl_addr   (fl_addr),
    .o_fl_ce_n   (fl_ce_n),
    .o_fl_oe_n   (fl_oe_n),
    .i_fl_rdata  (fl_rdata),
    .o_busy      (busy),
    .o_drop      (drop)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_req = 1'b0;
    ppu_req = 1'b0;
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  int          ack_c, ack_p, oe_cnt, nacks, idle_cnt;
  logic [7:0]  rd_c, rd_p;
  logic [22:0] addr10;
  logic        ce10, oe10, last_p, order_ok;
  int          prev_ack, gap_bad;
  logic        outst [2];
  logic [22:0] maddr [2];
  logic        mdrop [2];
  int          age [2];
  logic [1:0]  ack;
  logic        rq [2];
  logic [22:0] ra [2];
  int          run;

  initial begin
    // Reset state
    rstn = 1'b0;
    cyc();
    chk("rst_ce_n", fl_ce_n, 1);
    chk("rst_oe_n", fl_oe_n, 1);
    chk("rst_addr", fl_addr, 0);
    chk("rst_acks", {cpu_ack, ppu_ack}, 0);
    chk("rst_rdata", {cpu_rdata, ppu_rdata}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    do_reset();

    // Single CPU read
    cpu_req = 1'b1;
    cpu_addr = 23'h008000;
    ack_c = -1; oe_cnt = 0; rd_c = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      cpu_req = 1'b0;
      if (!fl_oe_n) oe_cnt++;
      if (cpu_ack && ack_c < 0) begin
        ack_c = i;
        rd_c = cpu_rdata;
      end
    end
    chk("single_ack_cyc", ack_c, 9);
    chk("single_rdata", rd_c, 8'hA5);
    chk("single_oe_len", oe_cnt, FW);
    chk("single_fl_addr", fl_addr, 23'h008000);
    chk("single_idle", busy, 0);

    // Simultaneous requests after reset
    do_reset();
    cpu_req = 1'b1; cpu_addr = 23'h000010;
    ppu_req = 1'b1; ppu_addr = 23'h400020;
    ack_c = -1; ack_p = -1; idle_cnt = 0;
    ce10 = 1'b1; oe10 = 1'b0; addr10 = '0;
    for (int i = 1; i <= 25; i++) begin
      cyc();
      cpu_req = 1'b0;
      ppu_req = 1'b0;
      if (cpu_ack && ack_c < 0) begin
        ack_c = i; rd_c = cpu_rdata;
      end
      if (ppu_ack && ack_p < 0) begin
        ack_p = i; rd_p = ppu_rdata;
      end
      if (i == 10) begin
        ce10 = fl_ce_n; oe10 = fl_oe_n; addr10 = fl_addr;
      end
      if (i >= 2 && i <= 17 && !busy) idle_cnt++;
    end
    chk("tie_ppu_ack", ack_p, 9);
    chk("tie_cpu_ack", ack_c, 17);
    chk("tie_ppu_rdata", rd_p, 8'hC5);
    chk("tie_cpu_rdata", rd_c, 8'hB5);
    chk("tie_setup_ce", ce10, 0);
    chk("tie_setup_oe", oe10, 1);
    chk("tie_setup_addr", addr10, 23'h000010);
    chk("tie_busy_gap", idle_cnt, 0);

    // Alternating load, re-pulse on own ack
    do_reset();
    cpu_req = 1'b1; cpu_addr = 23'h000100;
    ppu_req = 1'b1; ppu_addr = 23'h400200;
    nacks = 0; idle_cnt = 0; order_ok = 1'b1;
    last_p = 1'b0; prev_ack = -1; gap_bad = 0;
    for (int i = 1; i <= 100 && nacks < 8; i++) begin
      cyc();
      cpu_req = 1'b0;
      ppu_req = 1'b0;
      if (i >= 2 && !busy) idle_cnt++;
      if (cpu_ack || ppu_ack) begin
        if (ppu_ack != ((nacks % 2) == 0)) order_ok = 1'b0;
        if (prev_ack >= 0 && i - prev_ack != FW + 2) gap_bad++;
        prev_ack = i;
        nacks++;
      end
      if (cpu_ack) begin
        cpu_req = 1'b1; cpu_addr = cpu_addr + 23'd1;
      end
      if (ppu_ack) begin
        ppu_req = 1'b1; ppu_addr = ppu_addr + 23'd1;
      end
    end
    chk("alt_nacks", nacks, 8);
    chk("alt_order", order_ok, 1);
    chk("alt_gap", gap_bad, 0);
    chk("alt_busy", idle_cnt, 0);

    // Second CPU pulse during WAIT is dropped
    do_reset();
    cpu_req = 1'b1; cpu_addr = 23'h001234;
    nacks = 0; rd_c = 8'h00;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      cpu_req = 1'b0;
      if (i == 5) begin
        cpu_req = 1'b1; cpu_addr = 23'h00ABCD;
      end
      if (cpu_ack) begin
        nacks++; rd_c = cpu_rdata;
      end
    end
    chk("drop_nacks", nacks, 1);
    chk("drop_rdata", rd_c, 8'h91);
    chk("drop_addr", fl_addr, 23'h001234);
    chk("drop_flag", drop, 2'b01);

    // Reset during WAIT
    do_reset();
    cpu_req = 1'b1; cpu_addr = 23'h003333;
    cyc();
    cpu_req = 1'b0;
    repeat (4) cyc();
    chk("rstw_in_wait", fl_oe_n, 0);
    #2 rstn = 1'b0;
    #1;
    chk("rstw_ce_n", fl_ce_n, 1);
    chk("rstw_oe_n", fl_oe_n, 1);
    chk("rstw_busy", busy, 0);
    cyc();
    rstn = 1'b1;
    nacks = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (cpu_ack || ppu_ack) nacks++;
    end
    chk("rstw_noack", nacks, 0);
    chk("rstw_idle", busy, 0);

    // Randomized traffic against the scoreboard
    do_reset();
    for (int p = 0; p < 2; p++) begin
      outst[p] = 1'b0; maddr[p] = '0;
      mdrop[p] = 1'b0; age[p] = 0;
    end
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      chk("rnd_drop", drop, {mdrop[1], mdrop[0]});
      ack = {ppu_ack, cpu_ack};
      chk("rnd_excl", ack == 2'b11, 0);
      if (!fl_oe_n) run++;
      else if (run != 0) begin
        chk("rnd_oe_len", run, FW);
        run = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (outst[p]) age[p]++;
        if (ack[p]) begin
          chk("rnd_ack_valid", outst[p], 1);
          chk("rnd_rdata", (p == 0) ? cpu_rdata : ppu_rdata,
              fdat(maddr[p]));
          chk("rnd_latency", age[p] <= 20, 1);
        end
        rq[p] = (i < 2900) && ($urandom % 6 == 0);
        ra[p] = 23'($urandom);
        if (rq[p]) begin
          if (!outst[p] || ack[p]) begin
            outst[p] = 1'b1; maddr[p] = ra[p]; age[p] = 0;
          end else begin
            mdrop[p] = 1'b1;
          end
        end else if (ack[p]) begin
          outst[p] = 1'b0;
        end
      end
      cpu_req = rq[0]; cpu_addr = ra[0];
      ppu_req = rq[1]; ppu_addr = ra[1];
    end
    chk("rnd_drain_cpu", outst[0], 0);
    chk("rnd_drain_ppu", outst[1], 0);
    chk("rnd_end_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
